sram_port_arbiter: RTL and testbench
====================================

# sram_port_arbiter

Two-requester arbiter and access sequencer for the single-port synchronous SRAM macro. It accepts read and write requests from two independent clients over valid/ready handshakes and grants them round-robin. It drives the SRAM's active-low chip, write and read strobes with the two-cycle assertion the macro's internal FSM requires, then returns a one-cycle response carrying the read data or a write acknowledgement. It sits directly in front of the SRAM; no other block touches the SRAM strobes.

## Interface
- ADDR_WIDTH, 8, SRAM address width; every address 0..2^ADDR_WIDTH-1 is valid.
- DATA_WIDTH, 8, SRAM data width.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low; shared with the SRAM.
- p0_req_valid / p1_req_valid  in  1  request pending on port 0 / port 1.
- p0_req_ready / p1_req_ready  out  1  request accepted this cycle when high together with valid.
- p0_req_write / p1_req_write  in  1  1 = write, 0 = read.
- p0_req_addr / p1_req_addr  in  ADDR_WIDTH  access address.
- p0_req_wdata / p1_req_wdata  in  DATA_WIDTH  write data; ignored for reads.
- p0_rsp_valid / p1_rsp_valid  out  1  one-cycle completion pulse for that port's request.
- rsp_rdata  out  DATA_WIDTH  read data, shared by both ports; qualified by a rsp_valid pulse on a read.
- busy  out  1  high in any state other than IDLE.
- sram_ce_n, sram_we_n, sram_re_n  out  1 each  SRAM strobes, registered.
- sram_addr  out  ADDR_WIDTH  SRAM address, registered.
- sram_wdata  out  DATA_WIDTH  SRAM write data, registered.
- sram_rdata  in  DATA_WIDTH  SRAM data_out (combinational on the SRAM side).

## Operation
- FSM states: IDLE, SETUP, ACCESS, RECOVER. Reset state is IDLE.
- Accept states are IDLE and RECOVER. In an accept state, the arbiter picks a winner among the valid ports and raises only that port's req_ready, combinationally.
  - Handshake: the winner's write, addr and wdata are latched together with its port id.
  - The FSM then moves to SETUP.
  - With no request, IDLE stays in IDLE and RECOVER moves to IDLE.
- Arbitration:
  - A single valid port always wins.
  - If both ports are valid, the port named by the priority pointer wins.
  - After every handshake the pointer moves to the other port.
  - The pointer resets to port 0.
- SETUP: sram_ce_n=0. Exactly one of sram_we_n / sram_re_n is 0, per the latched write bit. sram_addr and sram_wdata hold the latched values. Moves to ACCESS.
- ACCESS: strobes, address and data are identical to SETUP. The SRAM commits a write at the clock edge that ends ACCESS. For a read, sram_rdata is registered into rsp_rdata at that same edge. Moves to RECOVER.
- RECOVER:
  - All strobes are 1.
  - The latched port's rsp_valid is 1 for this cycle only.
  - rsp_rdata changes only on read completions; a write leaves it unchanged.
- Requesters must hold valid, write, addr and wdata stable until the handshake. A requester may drop valid before being granted; the arbiter then simply does not grant it.
- Nothing is buffered beyond the single in-flight access. req_ready is 0 in SETUP and ACCESS.

## Timing
- Reset values: all strobes 1, sram_addr 0, sram_wdata 0, rsp_rdata 0, both rsp_valid 0, both req_ready 0, busy 0.
- Assertion of rst_n forces these values immediately, asynchronously, in any state. An in-flight access is dropped with no response.
- Latency: handshake in cycle T puts strobes low in T+1 and T+2, rsp_valid and rsp_rdata in T+3.
- Peak throughput: one access per 3 cycles, since the next handshake may occur in the RECOVER cycle T+3.
- sram_ce_n is never low for more or fewer than 2 consecutive cycles.
- Between accesses, strobes are high for at least 1 cycle, which lets the SRAM FSM return to IDLE.
- sram_we_n and sram_re_n are never low together.
- busy is 1 from T+1 through T+3.

## Test plan
- Port0 writes 0xA5 to 0x3C, then port0 reads 0x3C.
  - Required: p0_rsp_valid pulses 3 cycles after each handshake.
  - Required: rsp_rdata=0xA5 on the read pulse.
  - Required: sram_ce_n low exactly 2 cycles per access.
- Both ports hold valid continuously from reset, port0 writing 0x11 to 0x00 and port1 writing 0x22 to 0xFF.
  - Required: grants alternate 0,1,0,1.
  - Required: handshakes at T, T+3, T+6, T+9.
  - Required: sram_we_n and sram_re_n never low together.
- Port1 writes 0x5A to 0x80, immediately followed by a port0 read of 0x80 accepted in the RECOVER cycle.
  - Required: port0 read returns 0x5A.
  - Required: p1_rsp_valid precedes p0_rsp_valid by 3 cycles.
- Port1 alone is valid while the pointer is on port0.
  - Required: port1 is granted in the same cycle.
  - Required: the next simultaneous request goes to port0.
- rst_n is asserted during ACCESS of a write of 0x77 to 0x10.
  - Required: strobes high immediately.
  - Required: no rsp_valid pulse.
  - Required: a post-reset read of 0x10 returns 0x00.
- Port0 reads 0x00 after 0xFF was written at 0xFF.
  - Required: rsp_rdata=0x00.
  - Required: a subsequent read of 0xFF returns 0xFF, exercising both ends of the address range.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// Two-port round-robin arbiter and strobe sequencer for a single-port synchronous SRAM.
// Each granted access holds the SRAM strobes low for exactly two cycles, then pulses a response.
module sram_port_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  p0_req_valid,
  output logic                  p0_req_ready,
  input  logic                  p0_req_write,
  input  logic [ADDR_WIDTH-1:0] p0_req_addr,
  input  logic [DATA_WIDTH-1:0] p0_req_wdata,
  output logic                  p0_rsp_valid,
  input  logic                  p1_req_valid,
  output logic                  p1_req_ready,
  input  logic                  p1_req_write,
  input  logic [ADDR_WIDTH-1:0] p1_req_addr,
  input  logic [DATA_WIDTH-1:0] p1_req_wdata,
  output logic                  p1_rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  busy,
  output logic                  sram_ce_n,
  output logic                  sram_we_n,
  output logic                  sram_re_n,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_wdata,
  input  logic [DATA_WIDTH-1:0] sram_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    ACCESS  = 2'd2,
    RECOVER = 2'd3
  } state_t;

  state_t                  state_r;
  state_t                  state_next_s;
  logic                    ptr_r;
  logic                    port_r;
  logic                    write_r;
  logic                    accept_s;
  logic                    grant_valid_s;
  logic                    grant_port_s;
  logic                    hs_s;
  logic                    req_write_s;
  logic [ADDR_WIDTH-1:0]   req_addr_s;
  logic [DATA_WIDTH-1:0]   req_wdata_s;
  logic                    write_next_s;
  logic                    strobe_on_s;
  logic                    ce_n_r;
  logic                    we_n_r;
  logic                    re_n_r;
  logic [ADDR_WIDTH-1:0]   addr_r;
  logic [DATA_WIDTH-1:0]   wdata_r;
  logic [DATA_WIDTH-1:0]   rdata_r;
  logic                    p0_rsp_r;
  logic                    p1_rsp_r;
  logic                    busy_r;

  // Winner selection among the valid ports; pointer only matters on a tie.
  always_comb begin
    accept_s      = 1'b0;
    grant_valid_s = 1'b0;
    grant_port_s  = 1'b0;
    case (state_r)
      IDLE, RECOVER: accept_s = 1'b1;
      default:       accept_s = 1'b0;
    endcase
    if (p0_req_valid && p1_req_valid) begin
      grant_valid_s = 1'b1;
      grant_port_s  = ptr_r;
    end else if (p0_req_valid) begin
      grant_valid_s = 1'b1;
      grant_port_s  = 1'b0;
    end else if (p1_req_valid) begin
      grant_valid_s = 1'b1;
      grant_port_s  = 1'b1;
    end else begin
      grant_valid_s = 1'b0;
      grant_port_s  = 1'b0;
    end
  end

  // Ready is gated by rst_n so it drops immediately while reset is held.
  assign hs_s         = accept_s & grant_valid_s & rst_n;
  assign p0_req_ready = hs_s & ~grant_port_s;
  assign p1_req_ready = hs_s & grant_port_s;

  // Request mux for the winning port.
  always_comb begin
    req_write_s = p0_req_write;
    req_addr_s  = p0_req_addr;
    req_wdata_s = p0_req_wdata;
    if (grant_port_s) begin
      req_write_s = p1_req_write;
      req_addr_s  = p1_req_addr;
      req_wdata_s = p1_req_wdata;
    end else begin
      req_write_s = p0_req_write;
      req_addr_s  = p0_req_addr;
      req_wdata_s = p0_req_wdata;
    end
  end

  // Next-state logic of the access sequencer.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (hs_s) begin
          state_next_s = SETUP;
        end else begin
          state_next_s = IDLE;
        end
      end
      SETUP:  state_next_s = ACCESS;
      ACCESS: state_next_s = RECOVER;
      RECOVER: begin
        if (hs_s) begin
          state_next_s = SETUP;
        end else begin
          state_next_s = IDLE;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Strobes are computed one cycle ahead so they come straight from flops.
  assign write_next_s = hs_s ? req_write_s : write_r;
  assign strobe_on_s  = (state_next_s == SETUP) || (state_next_s == ACCESS);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Latch the winning request and advance the round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r   <= 1'b0;
      port_r  <= 1'b0;
      write_r <= 1'b0;
      addr_r  <= {ADDR_WIDTH{1'b0}};
      wdata_r <= {DATA_WIDTH{1'b0}};
    end else if (hs_s) begin
      ptr_r   <= ~grant_port_s;
      port_r  <= grant_port_s;
      write_r <= req_write_s;
      addr_r  <= req_addr_s;
      wdata_r <= req_wdata_s;
    end
  end

  // Registered SRAM strobes and busy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ce_n_r <= 1'b1;
      we_n_r <= 1'b1;
      re_n_r <= 1'b1;
      busy_r <= 1'b0;
    end else begin
      ce_n_r <= ~strobe_on_s;
      we_n_r <= ~(strobe_on_s & write_next_s);
      re_n_r <= ~(strobe_on_s & ~write_next_s);
      busy_r <= (state_next_s != IDLE);
    end
  end

  // Response pulse and read-data capture at the edge that ends ACCESS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p0_rsp_r <= 1'b0;
      p1_rsp_r <= 1'b0;
      rdata_r  <= {DATA_WIDTH{1'b0}};
    end else begin
      p0_rsp_r <= (state_r == ACCESS) && !port_r;
      p1_rsp_r <= (state_r == ACCESS) && port_r;
      if ((state_r == ACCESS) && !write_r) begin
        rdata_r <= sram_rdata;
      end
    end
  end

  assign sram_ce_n    = ce_n_r;
  assign sram_we_n    = we_n_r;
  assign sram_re_n    = re_n_r;
  assign sram_addr    = addr_r;
  assign sram_wdata   = wdata_r;
  assign rsp_rdata    = rdata_r;
  assign p0_rsp_valid = p0_rsp_r;
  assign p1_rsp_valid = p1_rsp_r;
  assign busy         = busy_r;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomized bench for sram_port_arbiter: a transaction-level model (cycle budget, pointer,
// one in-flight access, reference memory) predicts every output each cycle.
module tb_sram_port_arbiter;

  logic       clk;
  logic       rst_n;
  logic       p0_req_valid, p0_req_ready, p0_req_write, p0_rsp_valid;
  logic       p1_req_valid, p1_req_ready, p1_req_write, p1_rsp_valid;
  logic [7:0] p0_req_addr, p0_req_wdata, p1_req_addr, p1_req_wdata;
  logic [7:0] rsp_rdata;
  logic       busy, sram_ce_n, sram_we_n, sram_re_n;
  logic [7:0] sram_addr, sram_wdata, sram_rdata;

  sram_port_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_write(p0_req_write),
    .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata), .p0_rsp_valid(p0_rsp_valid),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_write(p1_req_write),
    .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata), .p1_rsp_valid(p1_rsp_valid),
    .rsp_rdata(rsp_rdata), .busy(busy),
    .sram_ce_n(sram_ce_n), .sram_we_n(sram_we_n), .sram_re_n(sram_re_n),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  // SRAM macro model: commits a write only on the second consecutive low-ce edge.
  logic [7:0] sram_mem [256];
  int         sram_cnt;
  assign sram_rdata = sram_mem[sram_addr];
  always @(posedge clk) begin
    if (!sram_ce_n) begin
      if (sram_cnt == 1 && !sram_we_n) sram_mem[sram_addr] <= sram_wdata;
      sram_cnt <= sram_cnt + 1;
    end else begin
      sram_cnt <= 0;
    end
  end

  int n_vec = 0;
  int n_err = 0;

  // Reference model state.
  int         cyc, avail, last_hs, ce_run;
  bit         ptr, rearm;
  bit         if_v, if_p, if_w;
  int         if_rc;
  logic [7:0] if_a, if_d, last_rd;
  logic [7:0] mem_ref [256];
  bit         pv [2];
  bit         pw [2];
  logic [7:0] pa [2];
  logic [7:0] pd [2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    cyc = 0; avail = 0; last_hs = -100; ce_run = 0;
    ptr = 1'b0; if_v = 1'b0; last_rd = 8'h00; rearm = 1'b0;
  endtask

  task automatic drive_idle();
    p0_req_valid = 1'b0; p0_req_write = 1'b0; p0_req_addr = 8'h00; p0_req_wdata = 8'h00;
    p1_req_valid = 1'b0; p1_req_write = 1'b0; p1_req_addr = 8'h00; p1_req_wdata = 8'h00;
  endtask

  // Called at a negedge; valids are held high during reset to show ready stays low.
  task automatic do_reset();
    pv[0] = 1'b0; pv[1] = 1'b0;
    drive_idle();
    p0_req_valid = 1'b1; p1_req_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    check_eq("rst_ce_n", sram_ce_n, 1);
    check_eq("rst_we_n", sram_we_n, 1);
    check_eq("rst_re_n", sram_re_n, 1);
    check_eq("rst_p0_rsp", p0_rsp_valid, 0);
    check_eq("rst_p1_rsp", p1_rsp_valid, 0);
    check_eq("rst_p0_rdy", p0_req_ready, 0);
    check_eq("rst_p1_rdy", p1_req_ready, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_addr", sram_addr, 0);
    check_eq("rst_wdata", sram_wdata, 0);
    check_eq("rst_rdata", rsp_rdata, 0);
    drive_idle();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // One clock cycle: drive requests, predict and compare every output, advance the model.
  task automatic step();
    bit acc, hs, win, low, rsp;
    p0_req_valid = pv[0]; p0_req_write = pw[0]; p0_req_addr = pa[0]; p0_req_wdata = pd[0];
    p1_req_valid = pv[1]; p1_req_write = pw[1]; p1_req_addr = pa[1]; p1_req_wdata = pd[1];
    #1;
    acc = (cyc >= avail);
    if (pv[0] && pv[1]) win = ptr;
    else                win = pv[1];
    hs = acc && (pv[0] || pv[1]);
    check_eq("p0_ready", p0_req_ready, hs && !win);
    check_eq("p1_ready", p1_req_ready, hs && win);
    check_eq("busy", busy, (cyc > last_hs) && (cyc <= last_hs + 3));
    low = (cyc == last_hs + 1) || (cyc == last_hs + 2);
    check_eq("ce_n", sram_ce_n, !low);
    check_eq("we_n", sram_we_n, !(low && if_w));
    check_eq("re_n", sram_re_n, !(low && !if_w));
    if (low) begin
      check_eq("sram_addr", sram_addr, if_a);
      if (if_w) check_eq("sram_wdata", sram_wdata, if_d);
    end
    rsp = if_v && (cyc == if_rc);
    check_eq("p0_rsp", p0_rsp_valid, rsp && !if_p);
    check_eq("p1_rsp", p1_rsp_valid, rsp && if_p);
    if (rsp) begin
      if (if_w) mem_ref[if_a] = if_d;
      else      last_rd = mem_ref[if_a];
      if_v = 1'b0;
    end
    check_eq("rsp_rdata", rsp_rdata, last_rd);
    if (!sram_ce_n) begin
      ce_run++;
    end else begin
      if (ce_run != 0) check_eq("ce_len", ce_run, 2);
      ce_run = 0;
    end
    check_eq("we_re_excl", !sram_we_n && !sram_re_n, 0);
    if (hs) begin
      if_v = 1'b1; if_p = win; if_w = pw[win]; if_a = pa[win]; if_d = pd[win];
      if_rc = cyc + 3; last_hs = cyc; avail = cyc + 3; ptr = !win;
      if (!rearm) pv[win] = 1'b0;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic set_req(input int p, input bit w, input logic [7:0] a, input logic [7:0] d);
    pv[p] = 1'b1; pw[p] = w; pa[p] = a; pd[p] = d;
  endtask

  task automatic run_until_idle(input int max_cycles);
    int n = 0;
    while (pv[0] || pv[1] || if_v) begin
      if (n >= max_cycles) begin
        check_eq("drain_timeout", n, 0);
        break;
      end
      step();
      n++;
    end
    step();
  endtask

  initial begin
    clk = 1'b0;
    rst_n = 1'b1;
    drive_idle();
    for (int i = 0; i < 256; i++) begin
      sram_mem[i] = 8'h00;
      mem_ref[i]  = 8'h00;
    end
    pv[0] = 1'b0; pv[1] = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Both ends of the address range.
    set_req(1, 1'b1, 8'hFF, 8'hFF); run_until_idle(20);
    set_req(0, 1'b0, 8'h00, 8'h00); run_until_idle(20);
    set_req(0, 1'b0, 8'hFF, 8'h00); run_until_idle(20);

    // Write then read back on port 0.
    set_req(0, 1'b1, 8'h3C, 8'hA5); run_until_idle(20);
    set_req(0, 1'b0, 8'h3C, 8'h00); run_until_idle(20);

    // Port 1 write followed by a port 0 read taken in the RECOVER cycle.
    set_req(1, 1'b1, 8'h80, 8'h5A); step();
    set_req(0, 1'b0, 8'h80, 8'h00); run_until_idle(20);

    // Port 1 alone with pointer on port 0, then a tie.
    do_reset();
    set_req(1, 1'b0, 8'h3C, 8'h00); step();
    set_req(0, 1'b0, 8'h80, 8'h00);
    set_req(1, 1'b0, 8'hFF, 8'h00);
    run_until_idle(30);

    // Reset during ACCESS of a write; the write must not land.
    do_reset();
    set_req(0, 1'b1, 8'h10, 8'h77); step(); step();
    check_eq("pre_rst_ce", sram_ce_n, 0);
    do_reset();
    repeat (3) step();
    set_req(0, 1'b0, 8'h10, 8'h00); run_until_idle(20);

    // Both ports valid continuously from reset.
    do_reset();
    rearm = 1'b1;
    set_req(0, 1'b1, 8'h00, 8'h11);
    set_req(1, 1'b1, 8'hFF, 8'h22);
    repeat (10) step();
    rearm = 1'b0;
    run_until_idle(30);
    set_req(1, 1'b0, 8'h00, 8'h00); run_until_idle(20);

    // Random traffic, including requests withdrawn before grant.
    for (int c = 0; c < 800; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pv[p]) begin
          if ($urandom_range(0, 2) == 0) begin
            pv[p] = 1'b1;
            pw[p] = 1'($urandom_range(0, 1));
            pa[p] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                  : 8'($urandom_range(0, 3));
            pd[p] = 8'($urandom_range(0, 255));
          end
        end else if (!(pv[0] && pv[1] && cyc >= avail) && $urandom_range(0, 15) == 0) begin
          pv[p] = 1'b0;
        end
      end
      step();
    end
    run_until_idle(30);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
